// File: rtl/slider_bank_overlay_if.sv
// Video stream bundle (syncs + 24-bit pixel) used on both sides of the slider overlay.
interface slider_bank_overlay_if #(
  parameter int DATA_W = 24
);
  logic              hs;
  logic              vs;
  logic              de;
  logic [DATA_W-1:0] data;

  modport master (output hs, vs, de, data);
  modport slave  (input  hs, vs, de, data);
endinterface

// File: rtl/slider_bank_overlay.sv
// Draws a grid of equalizer sliders (caps, track, level marker) over a video stream, 2-cycle latency.
// Optional macro SLIDER_ALPHA_EN: caps and track are 50% blended with the video instead of opaque.
module slider_bank_overlay #(
  parameter int NUM_SLIDERS = 6,
  parameter int COLS        = 3,
  parameter int LEVEL_W     = 4,
  parameter int LEVEL_MAX   = 10,
  parameter int X0          = 25,
  parameter int Y0          = 20,
  parameter int PITCH_X     = 125,
  parameter int PITCH_Y     = 240,
  parameter int CAP_W       = 100,
  parameter int CAP_H       = 30,
  parameter int TRACK_H     = 140,
  parameter int KNOB_H      = 20,
  parameter int KNOB_HW     = 10,
  parameter int STEP        = 12,
  parameter logic [NUM_SLIDERS*24-1:0] PALETTE =
    {24'hff00ff, 24'h00ff00, 24'h00ffff, 24'hff0000, 24'h0000ff, 24'hffff00},
  parameter logic [23:0] HILITE     = 24'hffffff,
  parameter logic [23:0] KNOB_COLOR = 24'h808080
) (
  input  logic                           pclk,
  input  logic                           rst,
  slider_bank_overlay_if.slave           vid_in,
  slider_bank_overlay_if.master          vid_out,
  input  logic [NUM_SLIDERS*LEVEL_W-1:0] i_level,
  input  logic [7:0]                     i_sel,
  input  logic                           i_sel_valid
);

  typedef enum logic [1:0] {PAINT_NONE, PAINT_TINT, PAINT_KNOB} paint_t;

  logic [11:0] x_cnt;
  logic [11:0] y_cnt;
  logic        vs_prev;
  logic        de_prev;
  logic        vs_rise;
  logic        de_fall;

  logic [LEVEL_W-1:0] lvl_q [NUM_SLIDERS];
  logic [7:0]         sel_q;
  logic               sel_valid_q;

  assign vs_rise = vid_in.vs & ~vs_prev;
  assign de_fall = de_prev & ~vid_in.de;

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      vs_prev <= vid_in.vs;
      de_prev <= vid_in.de;
      if (!vid_in.de)
        x_cnt <= '0;
      else if (x_cnt != 12'hfff)
        x_cnt <= x_cnt + 12'd1;
      if (vs_rise)
        y_cnt <= '0;
      else if (de_fall && y_cnt != 12'hfff)
        y_cnt <= y_cnt + 12'd1;
    end
  end

  // Levels and selection only move at frame start so a frame never tears.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLIDERS; i++)
        lvl_q[i] <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
    end else if (vs_rise) begin
      for (int i = 0; i < NUM_SLIDERS; i++) begin
        if (i_level[i*LEVEL_W +: LEVEL_W] > LEVEL_W'(LEVEL_MAX))
          lvl_q[i] <= LEVEL_W'(LEVEL_MAX);
        else
          lvl_q[i] <= i_level[i*LEVEL_W +: LEVEL_W];
      end
      sel_q       <= i_sel;
      sel_valid_q <= i_sel_valid && (i_sel < 8'(NUM_SLIDERS));
    end
  end

  logic [12:0] xe;
  logic [12:0] ye;
  logic [NUM_SLIDERS-1:0] knob_hit, cap_hit, cap_hi_hit, track_hit;

  assign xe = {1'b0, x_cnt};
  assign ye = {1'b0, y_cnt};

  for (genvar i = 0; i < NUM_SLIDERS; i++) begin : g_slider
    localparam int L         = X0 + (i % COLS) * PITCH_X;
    localparam int C         = L + CAP_W / 2;
    localparam int T         = Y0 + (i / COLS) * PITCH_Y;
    localparam int KNOB_BASE = T + CAP_H + TRACK_H - KNOB_H;

    logic [12:0] kt;
    logic        cap_x;
    logic        top_y;
    logic        bot_y;

    assign kt    = 13'(KNOB_BASE) - 13'(lvl_q[i]) * 13'(STEP);
    assign cap_x = (xe >= 13'(L)) && (xe <= 13'(L + CAP_W));
    assign top_y = (ye >= 13'(T)) && (ye <= 13'(T + CAP_H));
    assign bot_y = (ye >= 13'(T + CAP_H + TRACK_H)) && (ye <= 13'(T + 2*CAP_H + TRACK_H));

    assign cap_hit[i]    = cap_x && (top_y || bot_y);
    assign cap_hi_hit[i] = cap_hit[i] && sel_valid_q && (sel_q == 8'(i));
    assign track_hit[i]  = (xe == 13'(C)) && (ye > 13'(T + CAP_H)) &&
                           (ye < 13'(T + CAP_H + TRACK_H));
    assign knob_hit[i]   = (ye >= kt) && (ye <= kt + 13'(KNOB_H - 1)) &&
                           (xe >= 13'(C - KNOB_HW)) && (xe <= 13'(C + KNOB_HW));
  end

  logic [NUM_SLIDERS-1:0] knob_q, cap_q, cap_hi_q, track_q;
  logic                   d1_hs, d1_vs, d1_de;
  logic [23:0]            d1_data;

  always_ff @(posedge pclk) begin
    if (rst) begin
      knob_q   <= '0;
      cap_q    <= '0;
      cap_hi_q <= '0;
      track_q  <= '0;
      d1_hs    <= 1'b0;
      d1_vs    <= 1'b0;
      d1_de    <= 1'b0;
      d1_data  <= '0;
    end else begin
      knob_q   <= knob_hit;
      cap_q    <= cap_hit;
      cap_hi_q <= cap_hi_hit;
      track_q  <= track_hit;
      d1_hs    <= vid_in.hs;
      d1_vs    <= vid_in.vs;
      d1_de    <= vid_in.de;
      d1_data  <= vid_in.data;
    end
  end

  paint_t      paint;
  logic [23:0] paint_colour;
  logic [23:0] next_data;

  // Later sliders overwrite earlier ones; within a slider the level marker beats caps beats track.
  always_comb begin
    paint        = PAINT_NONE;
    paint_colour = '0;
    for (int i = 0; i < NUM_SLIDERS; i++) begin
      if (knob_q[i]) begin
        paint        = PAINT_KNOB;
        paint_colour = KNOB_COLOR;
      end else if (cap_q[i]) begin
        paint        = PAINT_TINT;
        paint_colour = cap_hi_q[i] ? HILITE : PALETTE[i*24 +: 24];
      end else if (track_q[i]) begin
        paint        = PAINT_TINT;
        paint_colour = PALETTE[i*24 +: 24];
      end
    end
  end

`ifdef SLIDER_ALPHA_EN
  function automatic logic [23:0] half_mix(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] r;
    for (int c = 0; c < 3; c++)
      r[c*8 +: 8] = {1'b0, a[c*8+1 +: 7]} + {1'b0, b[c*8+1 +: 7]};
    return r;
  endfunction

  always_comb begin
    next_data = d1_data;
    if (d1_de && paint == PAINT_KNOB)
      next_data = paint_colour;
    else if (d1_de && paint == PAINT_TINT)
      next_data = half_mix(d1_data, paint_colour);
  end
`else
  always_comb begin
    next_data = d1_data;
    if (d1_de && paint != PAINT_NONE)
      next_data = paint_colour;
  end
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      vid_out.hs   <= 1'b0;
      vid_out.vs   <= 1'b0;
      vid_out.de   <= 1'b0;
      vid_out.data <= '0;
    end else begin
      vid_out.hs   <= d1_hs;
      vid_out.vs   <= d1_vs;
      vid_out.de   <= d1_de;
      vid_out.data <= next_data;
    end
  end

endmodule

// File: tb/tb_slider_bank_overlay.sv
// Directed bench for slider_bank_overlay: reset, geometry, clamping, frame latch and highlight.
module tb_slider_bank_overlay;

  logic        pclk = 1'b0;
  logic        rst;
  logic [23:0] i_level;
  logic [7:0]  i_sel;
  logic        i_sel_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int in00_cyc = -1;
  int out00_cyc = -1;

  slider_bank_overlay_if vid_in ();
  slider_bank_overlay_if vid_out ();

  slider_bank_overlay dut (
    .pclk        (pclk),
    .rst         (rst),
    .vid_in      (vid_in),
    .vid_out     (vid_out),
    .i_level     (i_level),
    .i_sel       (i_sel),
    .i_sel_valid (i_sel_valid)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Rebuild output coordinates from the delayed syncs and store every active pixel of the frame.
  logic [23:0] cap_mem [int];
  int   ox = 0;
  int   oy = 0;
  logic ovs_prev = 1'b0;
  logic ode_prev = 1'b0;

  always @(negedge pclk) begin
    if (vid_out.vs && !ovs_prev) begin
      cap_mem.delete();
      oy = 0;
      out00_cyc = -1;
    end
    if (vid_out.de) begin
      cap_mem[oy*4096 + ox] = vid_out.data;
      if (ox == 0 && oy == 0) out00_cyc = cyc;
      ox++;
    end else begin
      if (ode_prev) oy++;
      ox = 0;
    end
    ovs_prev = vid_out.vs;
    ode_prev = vid_out.de;
  end

  function automatic logic [23:0] tint(input logic [23:0] c);
`ifdef SLIDER_ALPHA_EN
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`else
    return c;
`endif
  endfunction

  function automatic int line_width(input int y);
    case (y)
      20, 50, 51:                              return 380;
      169, 170, 180, 189, 190:                 return 130;
      290, 300, 309, 310, 409, 410, 420, 429, 430: return 215;
      default:                                 return 2;
    endcase
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic applyStimulus(input logic hs, input logic vs, input logic de,
                               input logic [23:0] data);
    vid_in.hs   = hs;
    vid_in.vs   = vs;
    vid_in.de   = de;
    vid_in.data = data;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkPixel(input string tag, input int x, input int y, input logic [23:0] exp);
    logic [31:0] obs;
    obs = cap_mem.exists(y*4096 + x) ? {8'h00, cap_mem[y*4096 + x]} : 32'hxxxxxxxx;
    checkOutput(tag, obs, {8'h00, exp});
  endtask

  // Levels/selection given here take effect at line 200 of this frame, i.e. only for the next frame.
  task automatic runFrame(input logic [23:0] mid_level, input logic [7:0] mid_sel,
                          input logic mid_valid);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 24'h5a5a5a);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 24'h5a5a5a);
    checkOutput("blank_pass", {8'h00, vid_out.data}, 32'h005a5a5a);
    for (int y = 0; y < 432; y++) begin
      if (y == 200) begin
        i_level     = mid_level;
        i_sel       = mid_sel;
        i_sel_valid = mid_valid;
      end
      for (int x = 0; x < line_width(y); x++) begin
        if (x == 0 && y == 0) in00_cyc = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1, (x == 0 && y == 0) ? 24'h123456 : 24'h000000);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000);
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000);
      applyStimulus(1'b0, 1'b0, 1'b0, 24'h000000);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 24'h000000);
  endtask

  initial begin
    rst         = 1'b1;
    i_level     = '0;
    i_sel       = '0;
    i_sel_valid = 1'b0;
    vid_in.hs   = 1'b0;
    vid_in.vs   = 1'b0;
    vid_in.de   = 1'b0;
    vid_in.data = '0;
    tick();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 24'hffffff);
    checkOutput("rst_hs",   {31'd0, vid_out.hs}, 32'd0);
    checkOutput("rst_vs",   {31'd0, vid_out.vs}, 32'd0);
    checkOutput("rst_de",   {31'd0, vid_out.de}, 32'd0);
    checkOutput("rst_data", {8'h00, vid_out.data}, 32'd0);

    rst = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 24'hffffff);
    checkOutput("run_de",   {31'd0, vid_out.de}, 32'd1);
    checkOutput("run_data", {8'h00, vid_out.data}, 32'h00ffffff);

    // Reset lands in the middle of an active line.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 24'hffffff);
    checkOutput("mid_rst_hs",   {31'd0, vid_out.hs}, 32'd0);
    checkOutput("mid_rst_vs",   {31'd0, vid_out.vs}, 32'd0);
    checkOutput("mid_rst_de",   {31'd0, vid_out.de}, 32'd0);
    checkOutput("mid_rst_data", {8'h00, vid_out.data}, 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 24'hffffff);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 24'h000000);

    // Frame A: band 4 at level 10, slider 2 selected.
    i_level     = 24'h0a0000;
    i_sel       = 8'd2;
    i_sel_valid = 1'b1;
    runFrame(24'h000000, 8'd9, 1'b1);
    checkOutput("latency00", out00_cyc - in00_cyc, 32'd2);
    checkPixel("A_px00",       0,   0, 24'h123456);
    checkPixel("A_knob0_tl",  65, 170, 24'h808080);
    checkPixel("A_knob0_br",  85, 189, 24'h808080);
    checkPixel("A_knob0_mid", 75, 180, 24'h808080);
    checkPixel("A_knob0_l",   64, 180, 24'h000000);
    checkPixel("A_knob0_r",   86, 170, 24'h000000);
    checkPixel("A_track0",    75, 169, tint(24'hffff00));
    checkPixel("A_bcap0",     75, 190, tint(24'hffff00));
    checkPixel("A_cap0_tl",   25,  20, tint(24'hffff00));
    checkPixel("A_cap0_br",  125,  50, tint(24'hffff00));
    checkPixel("A_cap0_l",    24,  20, 24'h000000);
    checkPixel("A_cap0_r",   126,  50, 24'h000000);
    checkPixel("A_cap1",     200,  20, tint(24'h0000ff));
    checkPixel("A_cap2_hi_l",275,  20, tint(24'hffffff));
    checkPixel("A_cap2_hi_r",375,  50, tint(24'hffffff));
    checkPixel("A_cap2_out", 376,  20, 24'h000000);
    checkPixel("A_track2",   325,  51, tint(24'hff0000));
    checkPixel("A_knob4_tl", 190, 290, 24'h808080);
    checkPixel("A_knob4_br", 210, 309, 24'h808080);
    checkPixel("A_cap4",     189, 290, tint(24'h00ff00));
    checkPixel("A_track4_lo",200, 310, tint(24'h00ff00));
    checkPixel("A_track4_x", 211, 300, 24'h000000);
    checkPixel("A_track4_old",200,420, tint(24'h00ff00));

    // Frame B: band 4 now at level 0, selection out of range.
    runFrame(24'h0f0000, 8'd9, 1'b1);
    checkPixel("B_knob4_top", 200, 410, 24'h808080);
    checkPixel("B_knob4_br",  210, 429, 24'h808080);
    checkPixel("B_track4_up", 200, 409, tint(24'h00ff00));
    checkPixel("B_track4_old",200, 300, tint(24'h00ff00));
    checkPixel("B_bcap4",     200, 430, tint(24'h00ff00));
    checkPixel("B_cap2_nohi", 275,  20, tint(24'hff0000));
    checkPixel("B_track2",    325,  51, tint(24'hff0000));

    // Frame C: band 4 requested at 15, clamps to level 10.
    runFrame(24'h0f0000, 8'd9, 1'b1);
    checkPixel("C_knob4_tl",  190, 290, 24'h808080);
    checkPixel("C_knob4_br",  210, 309, 24'h808080);
    checkPixel("C_track4_lo", 200, 310, tint(24'h00ff00));
    checkPixel("C_track4_hi", 200, 410, tint(24'h00ff00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
